word_collector: RTL and testbench

WORD_COLLECTOR -- requirements
Module: word_collector

---
 rtl/word_collector_pkg.sv | 16 +
 rtl/word_collector_letter_buffer.sv | 36 +++
 rtl/word_collector.sv | 112 +++++++++++
 tb/tb_word_collector.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/word_collector_pkg.sv
// Shared constants and FSM encoding for the word collector and its letter buffer.
package word_collector_pkg;

  localparam int unsigned MAX_LEN    = 6;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned LETTER_MAX = 25;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

endpackage

// File: rtl/word_collector_letter_buffer.sv
// Letter storage: write one slot, clear one slot, or clear every slot.
module letter_buffer
  import word_collector_pkg::*;
#(
  parameter int unsigned LEN  = MAX_LEN,
  parameter int unsigned CW   = CODE_W,
  parameter int unsigned IDXW = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [CW-1:0]    wr_code,
  input  logic             clr_en,
  input  logic [IDXW-1:0]  clr_idx,
  input  logic             clr_all,
  output logic [LEN*CW-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clr_all) begin
      word <= '0;
    end else begin
      for (int unsigned i = 0; i < LEN; i++) begin
        if (wr_en && wr_idx == IDXW'(i)) begin
          word[i*CW +: CW] <= wr_code;
        end else if (clr_en && clr_idx == IDXW'(i)) begin
          word[i*CW +: CW] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/word_collector.sv
// Collects keyed letters into a word and emits a one-cycle commit pulse for the chip decoder.
module word_collector
  import word_collector_pkg::*;
#(
  parameter int unsigned MAX_LEN = word_collector_pkg::MAX_LEN,
  parameter int unsigned CODE_W  = word_collector_pkg::CODE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [CODE_W-1:0]         key_code,
  input  logic                      key_back,
  input  logic                      key_enter,
  output logic [2:0]                cnt,
  output logic                      en,
  output logic [MAX_LEN*CODE_W-1:0] word,
  output logic                      full,
  output logic                      reject
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               reject_next;
  logic               wr_en, clr_en, clr_all;
  logic [IDX_W-1:0]   wr_idx, clr_idx;
  logic               any_key;

  assign any_key = key_valid | key_back | key_enter;

  // State, count and pulse registers; en is high exactly while in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      cnt    <= '0;
      en     <= 1'b0;
      full   <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      en     <= (state_next == ST_COMMIT);
      full   <= (cnt_next == CNT_W'(MAX_LEN));
      reject <= reject_next;
    end
  end

  // Next-state and buffer control; enter beats back beats letter.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    reject_next = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = IDX_W'(cnt);
    clr_en      = 1'b0;
    clr_idx     = IDX_W'(cnt - CNT_W'(1));
    clr_all     = 1'b0;
    case (state)
      ST_EMPTY, ST_ENTRY: begin
        if (key_enter) begin
          if (state == ST_ENTRY) state_next = ST_COMMIT;
          else                   reject_next = 1'b1;
        end else if (key_back) begin
          if (state == ST_ENTRY) begin
            clr_en   = 1'b1;
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_next = ST_EMPTY;
          end else begin
            reject_next = 1'b1;
          end
        end else if (key_valid) begin
          if (key_code > CODE_W'(LETTER_MAX) || cnt == CNT_W'(MAX_LEN)) begin
            reject_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            cnt_next   = cnt + CNT_W'(1);
            state_next = ST_ENTRY;
          end
        end
      end
      ST_COMMIT: begin
        state_next  = ST_CLEAR;
        reject_next = any_key;
      end
      ST_CLEAR: begin
        state_next  = ST_EMPTY;
        cnt_next    = '0;
        clr_all     = 1'b1;
        reject_next = any_key;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  letter_buffer #(
    .LEN  (MAX_LEN),
    .CW   (CODE_W),
    .IDXW (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_code (key_code),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .clr_all (clr_all),
    .word    (word)
  );

endmodule

// File: tb/tb_word_collector.sv
// Directed scoreboard bench for word_collector.
module tb_word_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, key_back, key_enter;
  logic [4:0]  key_code;
  logic [2:0]  cnt;
  logic        en, full, reject;
  logic [29:0] word;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [2:0]  cnt;
    logic        en;
    logic        reject;
    logic [29:0] word;
  } exp_t;

  exp_t sb[$];

  word_collector dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_back  (key_back),
    .key_enter (key_enter),
    .cnt       (cnt),
    .en        (en),
    .word      (word),
    .full      (full),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pk(input int s[6]);
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w[i*5 +: 5] = 5'(s[i]);
    return w;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input int e, input int r, input logic [29:0] w);
    exp_t x;
    x.tag = tag; x.cnt = 3'(c); x.en = 1'(e); x.reject = 1'(r); x.word = w;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    x = sb.pop_front();
    cmp(x.tag, "cnt",    32'(cnt),    32'(x.cnt));
    cmp(x.tag, "en",     32'(en),     32'(x.en));
    cmp(x.tag, "reject", 32'(reject), 32'(x.reject));
    cmp(x.tag, "full",   32'(full),   32'(x.cnt == 3'd6));
    cmp(x.tag, "word",   32'(word),   32'(x.word));
  endtask

  // Drive strobes for one edge, then check the registered result just after it.
  task automatic step(input string tag, input int v, input int code, input int b, input int ent,
                      input int c, input int e, input int r, input logic [29:0] w);
    @(negedge clk);
    key_valid = 1'(v); key_code = 5'(code); key_back = 1'(b); key_enter = 1'(ent);
    push(tag, c, e, r, w);
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_back = 1'b0; key_enter = 1'b0; key_code = '0;
    pop_check();
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_back = 1'b0; key_enter = 1'b0; key_code = '0;
    #2;
    push("reset", 0, 0, 0, '0);
    pop_check();
    @(negedge clk); rst = 1'b0;

    // Basic word and commit timing
    step("l7",        1, 7,  0, 0, 1, 0, 0, pk('{7,0,0,0,0,0}));
    step("l4",        1, 4,  0, 0, 2, 0, 0, pk('{7,4,0,0,0,0}));
    step("l11",       1, 11, 0, 0, 3, 0, 0, pk('{7,4,11,0,0,0}));
    step("enter",     0, 0,  0, 1, 3, 1, 0, pk('{7,4,11,0,0,0}));
    step("clear",     0, 0,  0, 0, 3, 0, 0, pk('{7,4,11,0,0,0}));
    step("empty",     0, 0,  0, 0, 0, 0, 0, '0);

    // Fill to capacity, overflow letter rejected
    for (int i = 0; i < 6; i++) begin
      int s[6];
      for (int j = 0; j < 6; j++) s[j] = (j <= i) ? j : 0;
      step("fill", 1, i, 0, 0, i + 1, 0, 0, pk(s));
    end
    step("overflow",  1, 6,  0, 0, 6, 0, 1, pk('{0,1,2,3,4,5}));
    step("full_ent",  0, 0,  0, 1, 6, 1, 0, pk('{0,1,2,3,4,5}));
    step("full_clr",  0, 0,  0, 0, 6, 0, 0, pk('{0,1,2,3,4,5}));
    step("full_emp",  0, 0,  0, 0, 0, 0, 0, '0);

    // Backspace down to empty and below
    step("b_l1",      1, 1,  0, 0, 1, 0, 0, pk('{1,0,0,0,0,0}));
    step("b_l2",      1, 2,  0, 0, 2, 0, 0, pk('{1,2,0,0,0,0}));
    step("back1",     0, 0,  1, 0, 1, 0, 0, pk('{1,0,0,0,0,0}));
    step("back2",     0, 0,  1, 0, 0, 0, 0, '0);
    step("back3",     0, 0,  1, 0, 0, 0, 1, '0);
    step("back_idl",  0, 0,  0, 0, 0, 0, 0, '0);
    step("back_l9",   1, 9,  0, 0, 1, 0, 0, pk('{9,0,0,0,0,0}));
    step("back4",     0, 0,  1, 0, 0, 0, 0, '0);

    // Enter on empty, then simultaneous strobes resolve to enter
    step("ent_empty", 0, 0,  0, 1, 0, 0, 1, '0);
    step("ent_idle",  0, 0,  0, 0, 0, 0, 0, '0);
    step("p_l3",      1, 3,  0, 0, 1, 0, 0, pk('{3,0,0,0,0,0}));
    step("p_l4",      1, 4,  0, 0, 2, 0, 0, pk('{3,4,0,0,0,0}));
    step("p_all",     1, 5,  1, 1, 2, 1, 0, pk('{3,4,0,0,0,0}));
    step("p_clrkey",  1, 9,  0, 0, 2, 0, 1, pk('{3,4,0,0,0,0}));
    step("p_empty",   0, 0,  0, 0, 0, 0, 0, '0);

    // Illegal codes and letters during the busy window
    step("code26",    1, 26, 0, 0, 0, 0, 1, '0);
    step("c_l2",      1, 2,  0, 0, 1, 0, 0, pk('{2,0,0,0,0,0}));
    step("code31",    1, 31, 0, 0, 1, 0, 1, pk('{2,0,0,0,0,0}));
    step("c_enter",   0, 0,  0, 1, 1, 1, 0, pk('{2,0,0,0,0,0}));
    step("c_busy",    1, 8,  0, 0, 1, 0, 1, pk('{2,0,0,0,0,0}));
    step("c_empty",   0, 0,  0, 0, 0, 0, 0, '0);
    step("c_l5",      1, 5,  0, 0, 1, 0, 0, pk('{5,0,0,0,0,0}));
    step("c_back",    0, 0,  1, 0, 0, 0, 0, '0);

    // Reset in the middle of COMMIT
    step("r_l1",      1, 1,  0, 0, 1, 0, 0, pk('{1,0,0,0,0,0}));
    step("r_enter",   0, 0,  0, 1, 1, 1, 0, pk('{1,0,0,0,0,0}));
    #2 rst = 1'b1;
    #1;
    push("rst_mid", 0, 0, 0, '0);
    pop_check();
    @(posedge clk); #1;
    push("rst_hold", 0, 0, 0, '0);
    pop_check();
    @(negedge clk); rst = 1'b0;
    step("r_first",   1, 7,  0, 0, 1, 0, 0, pk('{7,0,0,0,0,0}));
    step("r_idle1",   0, 0,  0, 0, 1, 0, 0, pk('{7,0,0,0,0,0}));
    step("r_idle2",   0, 0,  0, 0, 1, 0, 0, pk('{7,0,0,0,0,0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
